// File: rtl/aoc_uart_pkg.sv
// aoc_uart_pkg: FSM states, ASCII codes and UART defaults shared by the score reporter.
package aoc_uart_pkg;
  typedef enum logic [1:0] {IDLE, CONV, SKIP, SEND} state_e;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int DEFAULT_CLKS_PER_BIT = 217;
  // floor(w*log10(2))+1: decimal digits of the largest w-bit unsigned value
  function automatic int num_digits(input int w);
    return ((w * 1233) >>> 12) + 1;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser; ready is high when idle or in the final stop-bit cycle,
// so a load in that cycle starts the next start bit with no idle gap.
module uart_tx_byte
  import aoc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  logic [9:0] sh_q, sh_d;
  logic [3:0] bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic act_q, act_d;
  logic end_bit;
  assign end_bit = cnt_q == C_LAST;
  assign ready   = !act_q || (end_bit && bit_q == 4'd9);
  assign tx      = sh_q[0];
  always_comb begin
    sh_d  = sh_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (act_q) begin
      cnt_d = end_bit ? '0 : cnt_q + 1'b1;
      if (end_bit) begin
        sh_d  = {1'b1, sh_q[9:1]};
        bit_d = bit_q + 4'd1;
      end
    end
    if (ready) begin
      act_d = load;
      cnt_d = '0;
      bit_d = '0;
      sh_d  = load ? {1'b1, data, 1'b0} : '1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '1;
      bit_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end
endmodule

// File: rtl/score_uart_tx.sv
// score_uart_tx: latches a score, converts it to decimal ASCII (leading zeros dropped) and sends it 8N1.
// Define SCORE_TX_CRLF_EN to append CR LF after the digits.
module score_uart_tx
  import aoc_uart_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] score,
  input  logic             score_valid,
  output logic             tx,
  output logic             busy,
  output logic             done
);
  localparam int ND = num_digits(WIDTH);
  localparam int BW = 4 * ND;
  localparam int IW = $clog2(WIDTH + 1);
  localparam int DW = $clog2(ND + 1);
  localparam logic [IW-1:0] IT_LAST  = IW'(WIDTH - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(ND - 1);
`ifdef SCORE_TX_CRLF_EN
  localparam logic [1:0] TAIL_N = 2'd2;
`else
  localparam logic [1:0] TAIL_N = 2'd0;
`endif
  state_e state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [IW-1:0] it_q, it_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [1:0] tail_q, tail_d;
  logic load, ready;
  logic [7:0] data;
  logic [3:0] top;
  // digits are consumed from the top nibble; dig_q counts digits still to send
  assign top  = bcd_q[BW-1 -: 4];
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    it_d    = it_q;
    dig_d   = dig_q;
    tail_d  = tail_q;
    load    = 1'b0;
    done    = 1'b0;
    data    = ASCII_ZERO | {4'h0, top};
    adj     = bcd_q;
    for (int i = 0; i < ND; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    case (state_q)
      IDLE: if (score_valid) begin
        state_d = CONV;
        bin_d   = score;
        bcd_d   = '0;
        it_d    = '0;
        tail_d  = '0;
      end
      CONV: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        it_d = it_q + 1'b1;
        if (it_q == IT_LAST) begin
          state_d = SKIP;
          dig_d   = DIG_LAST;
        end
      end
      SKIP: begin
        bcd_d = bcd_q << 4;
        if (top != 4'd0 || dig_q == '0) begin
          load    = 1'b1;
          state_d = SEND;
        end else dig_d = dig_q - 1'b1;
      end
      SEND: if (ready) begin
        if (dig_q != '0) begin
          load  = 1'b1;
          bcd_d = bcd_q << 4;
          dig_d = dig_q - 1'b1;
        end else if (tail_q != TAIL_N) begin
          load   = 1'b1;
          data   = (tail_q == 2'd0) ? ASCII_CR : ASCII_LF;
          tail_d = tail_q + 2'd1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      it_q    <= '0;
      dig_q   <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      it_q    <= it_d;
      dig_q   <= dig_d;
      tail_q  <= tail_d;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .data (data),
    .tx   (tx),
    .ready(ready)
  );
endmodule

// File: tb/tb_score_uart_tx.sv
// tb_score_uart_tx: directed scores against a per-cycle line model plus a mid-bit UART monitor.
module tb_score_uart_tx;
  localparam int CPB     = 4;
  localparam int FRAME   = 10 * CPB;
  localparam int MAX_LAT = 32 + 10 + 2;
`ifdef SCORE_TX_CRLF_EN
  localparam int NTAIL = 2;
`else
  localparam int NTAIL = 0;
`endif
  logic clk = 1'b0;
  logic rst_n, score_valid, tx, busy, done;
  logic [31:0] score;
  score_uart_tx #(.WIDTH(32), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
    .tx(tx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0;
  logic sv_prev = 1'b0;
  logic [31:0] sc_prev = '0;
  int m_state = 0, m_pos = 0, acc_cyc = 0, start_cyc = 0, done_cnt = 0, last_span = 0;
  int mon_act = 0, mon_off = 0;
  logic [7:0] exp_b[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask
  // expected character string from plain decimal arithmetic
  function automatic void build(input logic [31:0] v);
    exp_b.delete();
    if (v == 0) exp_b.push_back(8'h30);
    while (v != 0) begin
      exp_b.push_front(8'h30 + 8'(v % 10));
      v = v / 10;
    end
`ifdef SCORE_TX_CRLF_EN
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
`endif
  endfunction
  function automatic logic fbit(input int p);
    int b;
    logic [7:0] by;
    b  = (p % FRAME) / CPB;
    by = exp_b[p / FRAME];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction
  always @(posedge clk) begin
    cyc++;
    sv_prev = score_valid;
    sc_prev = score;
  end
  // model states: 0 idle, 1 accepted and waiting for first start bit, 2 sending
  always @(negedge clk) begin
    logic last;
    if (!rst_n) begin
      m_state = 0;
      mon_act = 0;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end else begin
      case (m_state)
        0: if (sv_prev) begin
          m_state = 1;
          acc_cyc = cyc - 1;
          build(sc_prev);
        end
        2: if (m_pos == FRAME * exp_b.size() - 1) m_state = 0; else m_pos++;
        default: ;
      endcase
      if (m_state == 1 && tx == 1'b0) begin
        m_state   = 2;
        m_pos     = 0;
        start_cyc = cyc;
        chk("latency", (cyc - acc_cyc) <= MAX_LAT, 1);
      end
      if (m_state == 1 && (cyc - acc_cyc) > MAX_LAT) begin
        checks++;
        errors++;
        $display("FAIL start_timeout: no start bit after %0d cycles, want <= %0d", cyc - acc_cyc, MAX_LAT);
        m_state = 0;
      end
      last = (m_state == 2) && (m_pos == FRAME * exp_b.size() - 1);
      chk("tx", tx, (m_state == 2) ? fbit(m_pos) : 1'b1);
      chk("busy", busy, m_state != 0);
      chk("done", done, last);
      if (last) begin
        done_cnt++;
        last_span = cyc - start_cyc + 1;
      end
      if (mon_act == 0) begin
        if (tx == 1'b0) begin
          mon_act = 1;
          mon_off = 0;
        end
      end else mon_off++;
      if (mon_act != 0) begin
        if (mon_off >= 6 && mon_off <= 34 && mon_off % 4 == 2) rx_byte[(mon_off - 6) / 4] = tx;
        if (mon_off == FRAME - 1) begin
          rx_q.push_back(rx_byte);
          mon_act = 0;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (m_state != 0 && k < 3000) begin
      tick();
      k++;
    end
    chk("idle_reached", m_state == 0, 1);
  endtask
  task automatic send(input logic [31:0] v);
    rx_q.delete();
    score = v;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    score = $urandom;
    tick();
    wait_idle();
  endtask
  task automatic chk_rx(input string nm, input logic [7:0] want[$], input int rep);
    logic [7:0] all[$];
    for (int r = 0; r < rep; r++) begin
      foreach (want[i]) all.push_back(want[i]);
`ifdef SCORE_TX_CRLF_EN
      all.push_back(8'h0D);
      all.push_back(8'h0A);
`endif
    end
    chk({nm, "_len"}, rx_q.size(), all.size());
    foreach (all[i])
      if (i < rx_q.size()) chk($sformatf("%s_byte%0d", nm, i), rx_q[i], all[i]);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    logic [7:0] want[$];
    int n;
    rst_n = 1'b0;
    score_valid = 1'b0;
    score = '0;
    repeat (3) tick();
    chk("por_tx", tx, 1);
    chk("por_busy", busy, 0);
    chk("por_done", done, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    send(32'd17092);
    want = '{8'h31, 8'h37, 8'h30, 8'h39, 8'h32};
    chk_rx("s17092", want, 1);
    chk("s17092_span", last_span, FRAME * (5 + NTAIL));
    send(32'd0);
    want = '{8'h30};
    chk_rx("zero", want, 1);
    chk("zero_span", last_span, FRAME * (1 + NTAIL));
    send(32'hFFFF_FFFF);
    want = '{8'h34, 8'h32, 8'h39, 8'h34, 8'h39, 8'h36, 8'h37, 8'h32, 8'h39, 8'h35};
    chk_rx("max", want, 1);
    chk("max_span", last_span, FRAME * (10 + NTAIL));
    rx_q.delete();
    n = done_cnt;
    score = 32'd7;
    score_valid = 1'b1;
    for (int k = 0; k < 3000 && done_cnt - n < 3; k++) tick();
    score_valid = 1'b0;
    wait_idle();
    chk("hold7_dones", done_cnt - n, 3);
    want = '{8'h37};
    chk_rx("hold7", want, 3);
    rx_q.delete();
    score = 32'd17092;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int k = 0; k < 200 && !(m_state == 2 && m_pos >= 13); k++) tick();
    chk("pre_rst_d2_tx", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("arst_no_frames", rx_q.size(), 0);
    send(32'd5);
    want = '{8'h35};
    chk_rx("after_rst", want, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
